// File: rtl/rt_score_ctrl_pkg.sv
// Shared constants, FSM encodings and adder flag helpers for the reaction-time score controller.
`ifndef RT_SCORE_CTRL_DEFS_SV
`define RT_SCORE_CTRL_DEFS_SV
`define RT_W         13
`define RT_BEST_INIT 13'h1FFF
`define RT_SAT_MAX   13'h1FFF
`define RT_ST_IDLE   3'd0
`define RT_ST_SUB    3'd1
`define RT_ST_CMP    3'd2
`define RT_ST_ACC    3'd3
`define RT_ST_FIN    3'd4
`endif

package rt_score_ctrl_pkg;

  localparam int W = `RT_W;
  localparam logic [W-1:0] BEST_INIT = `RT_BEST_INIT;
  localparam logic [W-1:0] SAT_MAX   = `RT_SAT_MAX;

  typedef enum logic [2:0] {
    ST_IDLE = `RT_ST_IDLE,
    ST_SUB  = `RT_ST_SUB,
    ST_CMP  = `RT_ST_CMP,
    ST_ACC  = `RT_ST_ACC,
    ST_FIN  = `RT_ST_FIN
  } state_t;

  // Unsigned borrow of X - Y recovered from the operand and result MSBs.
  function automatic logic sub_borrow(input logic x_msb, input logic y_msb, input logic s_msb);
    return (~x_msb & y_msb) | (~(x_msb ^ y_msb) & s_msb);
  endfunction

  // Unsigned carry of X + Y recovered from the operand and result MSBs.
  function automatic logic add_carry(input logic x_msb, input logic y_msb, input logic s_msb);
    return (x_msb & y_msb) | ((x_msb ^ y_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/rt_score_ctrl_addsub.sv
// Single 13-bit add/subtract unit shared by every arithmetic step of the controller.
module full_add_subtract13bit
  import rt_score_ctrl_pkg::*;
(
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_add_sub,   // 0 = X + Y, 1 = X - Y
  output logic [W-1:0] o_s
);

  logic [W-1:0] w_y_eff;
  logic [W-1:0] w_cin;

  // Subtraction is X + ~Y + 1, so one carry chain serves both modes.
  assign w_y_eff = i_y ^ {W{i_add_sub}};
  assign w_cin   = {{(W-1){1'b0}}, i_add_sub};
  assign o_s     = i_x + w_y_eff + w_cin;

endmodule

// File: rtl/rt_score_ctrl.sv
// Reaction-time scoring controller: per round computes elapsed time, tracks the best
// (minimum) time and a saturating total, and counts rounds until the game is over.
module rt_score_ctrl
  import rt_score_ctrl_pkg::*;
#(
  parameter int MAX_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] t_start,
  input  logic [W-1:0] t_stop,
  output logic [W-1:0] elapsed,
  output logic [W-1:0] best,
  output logic [W-1:0] total,
  output logic [3:0]   rounds,
  output logic         res_valid,
  output logic         sat,
  output logic         done
);

  localparam logic [W-1:0] MAX_W = W'(MAX_ROUNDS);

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_t_start;
  logic [W-1:0] r_t_stop;
  logic [W-1:0] r_elapsed;
  logic [W-1:0] r_best;
  logic [W-1:0] r_total;
  logic [3:0]   r_rounds;
  logic         r_res_valid;
  logic         r_sat;
  logic         r_done;

  logic [W-1:0] w_x;
  logic [W-1:0] w_y;
  logic         w_add_sub;
  logic [W-1:0] w_s;
  logic         w_accept;
  logic         w_borrow;
  logic         w_carry;

  assign req_ready = (r_state == ST_IDLE) && !r_done && !clr;
  assign w_accept  = req_valid && req_ready;

  full_add_subtract13bit u_addsub (
    .i_x       (w_x),
    .i_y       (w_y),
    .i_add_sub (w_add_sub),
    .o_s       (w_s)
  );

  assign w_borrow = sub_borrow(w_x[W-1], w_y[W-1], w_s[W-1]);
  assign w_carry  = add_carry(w_x[W-1], w_y[W-1], w_s[W-1]);

  // State register; reset and clear both abort any round in flight.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus operand/mode steering of the shared adder (idle: add 0 + 0).
  always_comb begin
    w_state_next = r_state;
    w_x          = '0;
    w_y          = '0;
    w_add_sub    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_SUB;
        end
      end
      ST_SUB: begin
        w_x          = r_t_stop;
        w_y          = r_t_start;
        w_add_sub    = 1'b1;
        w_state_next = ST_CMP;
      end
      ST_CMP: begin
        w_x          = r_best;
        w_y          = r_elapsed;
        w_add_sub    = 1'b1;
        w_state_next = ST_ACC;
      end
      ST_ACC: begin
        w_x          = r_total;
        w_y          = r_elapsed;
        w_state_next = ST_FIN;
      end
      ST_FIN: begin
        w_x          = {{(W-4){1'b0}}, r_rounds};
        w_y          = {{(W-1){1'b0}}, 1'b1};
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers, each updated in its own FSM step from the shared adder result.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      r_t_start   <= '0;
      r_t_stop    <= '0;
      r_elapsed   <= '0;
      r_best      <= BEST_INIT;
      r_total     <= '0;
      r_rounds    <= '0;
      r_res_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_t_start <= t_start;
        r_t_stop  <= t_stop;
      end
      case (r_state)
        ST_SUB: begin
          // Modulo-2^13 difference makes a wrapped timer stamp come out right.
          r_elapsed <= w_s;
        end
        ST_CMP: begin
          // best > elapsed exactly when best - elapsed neither borrows nor is zero.
          if (!w_borrow && (w_s != '0)) begin
            r_best <= r_elapsed;
          end
        end
        ST_ACC: begin
          if (w_carry) begin
            r_total <= SAT_MAX;
            r_sat   <= 1'b1;
          end else begin
            r_total <= w_s;
          end
        end
        ST_FIN: begin
          r_rounds    <= w_s[3:0];
          r_res_valid <= 1'b1;
          r_done      <= (w_s == MAX_W);
        end
        default: begin
        end
      endcase
    end
  end

  assign elapsed   = r_elapsed;
  assign best      = r_best;
  assign total     = r_total;
  assign rounds    = r_rounds;
  assign res_valid = r_res_valid;
  assign sat       = r_sat;
  assign done      = r_done;

endmodule

// File: doc/rt_score_ctrl.md
RT_SCORE_CTRL -- requirements
Module: rt_score_ctrl

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 10, the number of rounds per game (1..15).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port clr, input, 1, synchronous game clear.
REQ-005 SHALL have port req_valid, input, 1, round result offered.
REQ-006 SHALL have port req_ready, output, 1, controller accepts round result.
REQ-007 SHALL have port t_start, input, 13, free-running timer stamp at stimulus.
REQ-008 SHALL have port t_stop, input, 13, timer stamp at button press.
REQ-009 SHALL have port elapsed, output, 13, last reaction time.
REQ-010 SHALL have port best, output, 13, minimum elapsed this game.
REQ-011 SHALL have port total, output, 13, saturating sum of elapsed.
REQ-012 SHALL have port rounds, output, 4, rounds completed.
REQ-013 SHALL have port res_valid, output, 1, one-cycle pulse when all results are updated.
REQ-014 SHALL have port sat, output, 1, sticky flag: total saturated.
REQ-015 SHALL have port done, output, 1, high once rounds == MAX_ROUNDS.

Function
REQ-016 SHALL time-share exactly one 13-bit add/subtract unit for all arithmetic; no other adders on data paths.
REQ-017 SHALL implement FSM IDLE -> SUB -> CMP -> ACC -> FIN -> IDLE, one cycle per state.
REQ-018 req_ready SHALL be high only in IDLE with done low and clr low; transfer occurs when req_valid && req_ready, latching t_start/t_stop.
REQ-019 SUB: elapsed <= t_stop - t_start modulo 2^13; a stop stamp below the start stamp is timer wrap and is accepted.
REQ-020 CMP: compute best - elapsed; unsigned borrow = (~X[12] & Y[12]) | (~(X[12]^Y[12]) & S[12]); borrow low and result nonzero -> best <= elapsed.
REQ-021 ACC: compute total + elapsed; carry = (X[12]&Y[12]) | ((X[12]^Y[12]) & ~S[12]); carry -> total <= 13'h1FFF and sat <= 1, else total <= sum.
REQ-022 FIN: rounds <= rounds + 1, res_valid high for this cycle only; done asserts on the same edge rounds reaches MAX_ROUNDS.
REQ-023 Latency SHALL be fixed: handshake at edge N -> res_valid high in cycle N+4; next acceptance no earlier than edge N+4.
REQ-024 When done is high, req_ready SHALL stay low until clr or reset.
REQ-025 clr SHALL take priority over req_valid in the same cycle: no transfer occurs.
REQ-026 clr in any state SHALL abort the FSM to IDLE with no res_valid, and clear outputs to their reset values next cycle.
REQ-027 Adder SHALL be held in add mode with zero operands in IDLE to avoid toggling.

Reset
REQ-028 On reset_n low at a clock edge, all of the following SHALL hold next cycle:
- FSM in IDLE.
- elapsed = 0, total = 0, rounds = 0.
- best = 13'h1FFF.
- res_valid = 0, sat = 0, done = 0.
- req_ready = 1 once reset_n is high.
REQ-029 Reset mid-operation SHALL discard the in-flight round silently.

Structure
REQ-030 Shared header (`include-guarded defines) SHALL hold:
- FSM state encodings.
- Width constant 13.
- BEST_INIT 13'h1FFF.
- SAT_MAX 13'h1FFF.
REQ-031 SHALL instantiate exactly one full_add_subtract13bit as its sub-module; the operand/AddSub mux lives in rt_score_ctrl.

Verification
REQ-032 Reset, then one round with t_start=100, t_stop=350 -> res_valid 4 cycles after handshake; elapsed=250, best=250, total=250, rounds=1.
REQ-033 Wrap round with t_start=8100, t_stop=50 -> elapsed=142, best updates to 142.
REQ-034 Rounds with elapsed 300, 200, 200, 400 -> best=200 after each of the last three, total=1100.
REQ-035 Saturation: elapsed 5000 twice -> total=8191, sat=1; a further round keeps total=8191 and sat=1.
REQ-036 Game end with MAX_ROUNDS=2: after two rounds done=1 and req_ready=0 while req_valid is held; clr asserted together with req_valid -> no transfer, all outputs at reset values.
REQ-037 clr during CMP -> no res_valid; best=8191, rounds=0 next cycle.
